// File: rtl/sprite_scaler_renderer.sv
// Three-stage sprite renderer: box test and ROM addressing, palette index register,
// then transparency and background resolution into a registered pixel colour.
module sprite_scaler_renderer #(
    parameter int SPR_W      = 64,
    parameter int SPR_H      = 48,
    parameter int SCALE_LOG2 = 3,
    parameter int IDX_W      = 4,
    parameter bit TRANSP_EN  = 1'b1,
    parameter int TRANSP_IDX = 0,
    parameter int V_ACTIVE   = 480,
    parameter int ADDR_W     = $clog2(SPR_W * SPR_H)
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              enable,
    input  logic [3:0]        bg_red,
    input  logic [3:0]        bg_green,
    input  logic [3:0]        bg_blue,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pal_index,
    input  logic [3:0]        pal_red,
    input  logic [3:0]        pal_green,
    input  logic [3:0]        pal_blue,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              opaque
);

    localparam int BOX_W = SPR_W << SCALE_LOG2;
    localparam int BOX_H = SPR_H << SCALE_LOG2;

    logic [9:0]        r_px;
    logic [9:0]        r_py;
    logic              r_en;

    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_inbox_1;
    logic              r_blank_1;

    logic [IDX_W-1:0]  r_q_2;
    logic              r_inbox_2;
    logic              r_blank_2;

    logic [3:0]        r_red;
    logic [3:0]        r_green;
    logic [3:0]        r_blue;
    logic              r_opaque;

    logic              w_latch;
    logic signed [11:0] w_dx;
    logic signed [11:0] w_dy;
    logic              w_inbox;
    int                w_col;
    int                w_row;
    logic [ADDR_W-1:0] w_addr;
    logic              w_transp;
    logic              w_draw;

    // Position is only sampled once per frame, on the first blanked line.
    assign w_latch = (DrawY == 10'(V_ACTIVE)) && (DrawX == 10'd0);

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_px <= '0;
            r_py <= '0;
            r_en <= 1'b0;
        end else if (w_latch) begin
            r_px <= pos_x;
            r_py <= pos_y;
            r_en <= enable;
        end
    end

    // Zero-extended 12-bit difference: sign bit set means left of / above the sprite.
    assign w_dx = signed'({2'b00, DrawX}) - signed'({2'b00, r_px});
    assign w_dy = signed'({2'b00, DrawY}) - signed'({2'b00, r_py});

    always_comb begin
        w_inbox = 1'b0;
        w_col   = 0;
        w_row   = 0;
        w_addr  = '0;
        w_inbox = r_en && !w_dx[11] && !w_dy[11]
                  && (int'(w_dx) < BOX_W) && (int'(w_dy) < BOX_H);
        w_col   = int'(w_dx) >>> SCALE_LOG2;
        w_row   = int'(w_dy) >>> SCALE_LOG2;
        if (w_inbox) begin
            w_addr = ADDR_W'(w_row * SPR_W + w_col);
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_rom_addr <= '0;
            r_inbox_1  <= 1'b0;
            r_blank_1  <= 1'b0;
        end else begin
            r_rom_addr <= w_addr;
            r_inbox_1  <= w_inbox;
            r_blank_1  <= blank;
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_q_2     <= '0;
            r_inbox_2 <= 1'b0;
            r_blank_2 <= 1'b0;
        end else begin
            r_q_2     <= rom_q;
            r_inbox_2 <= r_inbox_1;
            r_blank_2 <= r_blank_1;
        end
    end

    assign w_transp = TRANSP_EN && (r_q_2 == IDX_W'(TRANSP_IDX));
    assign w_draw   = r_inbox_2 && !w_transp;

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_red    <= '0;
            r_green  <= '0;
            r_blue   <= '0;
            r_opaque <= 1'b0;
        end else if (!r_blank_2) begin
            r_red    <= '0;
            r_green  <= '0;
            r_blue   <= '0;
            r_opaque <= 1'b0;
        end else if (w_draw) begin
            r_red    <= pal_red;
            r_green  <= pal_green;
            r_blue   <= pal_blue;
            r_opaque <= 1'b1;
        end else begin
            r_red    <= bg_red;
            r_green  <= bg_green;
            r_blue   <= bg_blue;
            r_opaque <= 1'b0;
        end
    end

    assign rom_addr  = r_rom_addr;
    assign pal_index = r_q_2;
    assign red       = r_red;
    assign green     = r_green;
    assign blue      = r_blue;
    assign opaque    = r_opaque;

endmodule

// File: tb/tb_sprite_scaler_renderer.sv
// Bench for sprite_scaler_renderer: fixed vectors, reset/latch sequences, and a randomized
// stream against a screen-space model. A second instance has transparency disabled.
module tb_sprite_scaler_renderer;

    localparam int N_RND = 4000;

    logic        vga_clk = 1'b0;
    logic        reset;
    logic [9:0]  DrawX, DrawY, pos_x, pos_y;
    logic        blank, enable;
    logic [3:0]  bg_red, bg_green, bg_blue;

    logic [11:0] rom_addr, rom_addr2;
    logic [3:0]  rom_q, rom_q2, pal_index, pal_index2;
    logic [3:0]  pal_red, pal_green, pal_blue, pal_red2, pal_green2, pal_blue2;
    logic [3:0]  red, green, blue, red2, green2, blue2;
    logic        opaque, opaque2;

    logic [3:0]  rom [0:3071];

    int total = 0;
    int bad   = 0;

    always #5 vga_clk = ~vga_clk;

    function automatic logic [3:0] pr(input logic [3:0] i);
        return (i == 4'd5) ? 4'hF : i;
    endfunction
    function automatic logic [3:0] pg(input logic [3:0] i);
        return (i == 4'd5) ? 4'h0 : 4'(15 - int'(i));
    endfunction
    function automatic logic [3:0] pb(input logic [3:0] i);
        return (i == 4'd5) ? 4'h0 : 4'((int'(i) * 3) % 16);
    endfunction

    assign rom_q      = (rom_addr  < 12'd3072) ? rom[rom_addr]  : 4'h0;
    assign rom_q2     = (rom_addr2 < 12'd3072) ? rom[rom_addr2] : 4'h0;
    assign pal_red    = pr(pal_index);
    assign pal_green  = pg(pal_index);
    assign pal_blue   = pb(pal_index);
    assign pal_red2   = pr(pal_index2);
    assign pal_green2 = pg(pal_index2);
    assign pal_blue2  = pb(pal_index2);

    sprite_scaler_renderer dut (
        .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .pos_x(pos_x), .pos_y(pos_y), .enable(enable),
        .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
        .rom_addr(rom_addr), .rom_q(rom_q), .pal_index(pal_index),
        .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
        .red(red), .green(green), .blue(blue), .opaque(opaque)
    );

    sprite_scaler_renderer #(.TRANSP_EN(1'b0)) dut2 (
        .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .pos_x(pos_x), .pos_y(pos_y), .enable(enable),
        .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
        .rom_addr(rom_addr2), .rom_q(rom_q2), .pal_index(pal_index2),
        .pal_red(pal_red2), .pal_green(pal_green2), .pal_blue(pal_blue2),
        .red(red2), .green(green2), .blue(blue2), .opaque(opaque2)
    );

    typedef struct {
        int px; int py; bit en;
        int x;  int y;  bit blk;
        int addr;
        int r;  int g;  int b;  bit op;
        int r2; int g2; int b2; bit op2;
    } vec_t;

    vec_t vecs [11];

    int e_addr [N_RND];
    int e_r [N_RND], e_g [N_RND], e_b [N_RND], e_op [N_RND];
    int e_r2 [N_RND], e_g2 [N_RND], e_b2 [N_RND], e_op2 [N_RND];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input int r, input int g, input int b, input int op,
                           input int r2, input int g2, input int b2, input int op2);
        chk({nm, ".red"},     int'(red),     r);
        chk({nm, ".green"},   int'(green),   g);
        chk({nm, ".blue"},    int'(blue),    b);
        chk({nm, ".opaque"},  int'(opaque),  op);
        chk({nm, ".red2"},    int'(red2),    r2);
        chk({nm, ".green2"},  int'(green2),  g2);
        chk({nm, ".blue2"},   int'(blue2),   b2);
        chk({nm, ".opaque2"}, int'(opaque2), op2);
    endtask

    task automatic step(input int x, input int y, input bit b);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
        @(posedge vga_clk);
        #1;
    endtask

    task automatic latch(input int px, input int py, input bit en);
        pos_x  = 10'(px);
        pos_y  = 10'(py);
        enable = en;
        step(0, 480, 1'b0);
    endtask

    // Screen-space view: a 512x384 box of 8x8 blocks, each block one ROM pixel.
    function automatic void model(input int x, input int y, input bit blk,
                                  input int px, input int py, input bit en, input bit tr,
                                  output int addr, output int r, output int g, output int b,
                                  output int op);
        bit inbox;
        int idx;
        inbox = en && (x >= px) && (x < px + 64 * 8) && (y >= py) && (y < py + 48 * 8);
        addr  = inbox ? ((y - py) / 8) * 64 + (x - px) / 8 : 0;
        idx   = int'(rom[addr]);
        if (!blk) begin
            r = 0; g = 0; b = 0; op = 0;
        end else if (inbox && !(tr && idx == 0)) begin
            r = int'(pr(4'(idx))); g = int'(pg(4'(idx))); b = int'(pb(4'(idx))); op = 1;
        end else begin
            r = int'(bg_red); g = int'(bg_green); b = int'(bg_blue); op = 0;
        end
    endfunction

    initial begin
        int m_px, m_py, x, y, a2, sel;
        bit m_en, bl;

        for (int i = 0; i < 3072; i++) rom[i] = 4'(i % 16);
        rom[66] = 4'd5;

        reset = 1'b1;
        DrawX = '0; DrawY = '0; blank = 1'b0;
        pos_x = '0; pos_y = '0; enable = 1'b0;
        bg_red = 4'd1; bg_green = 4'd2; bg_blue = 4'd3;

        #2;
        chk("reset.rom_addr", int'(rom_addr), 0);
        chk_out("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        @(posedge vga_clk);
        #1;

        vecs[0]  = '{0,   0,  1'b1, 17,  9,   1'b1, 66,   15, 0,  0,  1'b1, 15, 0,  0,  1'b1};
        vecs[1]  = '{0,   0,  1'b1, 0,   0,   1'b1, 0,    1,  2,  3,  1'b0, 0,  15, 0,  1'b1};
        vecs[2]  = '{100, 0,  1'b1, 611, 0,   1'b1, 63,   15, 0,  13, 1'b1, 15, 0,  13, 1'b1};
        vecs[3]  = '{100, 0,  1'b1, 612, 0,   1'b1, 0,    1,  2,  3,  1'b0, 1,  2,  3,  1'b0};
        vecs[4]  = '{100, 0,  1'b1, 99,  0,   1'b1, 0,    1,  2,  3,  1'b0, 1,  2,  3,  1'b0};
        vecs[5]  = '{600, 0,  1'b1, 639, 0,   1'b1, 4,    4,  11, 12, 1'b1, 4,  11, 12, 1'b1};
        vecs[6]  = '{0,   0,  1'b0, 17,  9,   1'b1, 0,    1,  2,  3,  1'b0, 1,  2,  3,  1'b0};
        vecs[7]  = '{0,   0,  1'b1, 17,  9,   1'b0, 66,   0,  0,  0,  1'b0, 0,  0,  0,  1'b0};
        vecs[8]  = '{0,   10, 1'b1, 8,   9,   1'b1, 0,    1,  2,  3,  1'b0, 1,  2,  3,  1'b0};
        vecs[9]  = '{0,   0,  1'b1, 511, 383, 1'b1, 3071, 15, 0,  13, 1'b1, 15, 0,  13, 1'b1};
        vecs[10] = '{0,   0,  1'b1, 0,   384, 1'b1, 0,    1,  2,  3,  1'b0, 1,  2,  3,  1'b0};

        for (int i = 0; i < 11; i++) begin
            latch(vecs[i].px, vecs[i].py, vecs[i].en);
            step(vecs[i].x, vecs[i].y, vecs[i].blk);
            chk($sformatf("vec%0d.rom_addr", i), int'(rom_addr), vecs[i].addr);
            step(700, 500, 1'b0);
            step(700, 500, 1'b0);
            chk_out($sformatf("vec%0d", i), vecs[i].r, vecs[i].g, vecs[i].b, int'(vecs[i].op),
                    vecs[i].r2, vecs[i].g2, vecs[i].b2, int'(vecs[i].op2));
        end

        // Asynchronous reset in the middle of active video.
        latch(0, 0, 1'b1);
        step(17, 9, 1'b1);
        step(17, 9, 1'b1);
        step(17, 9, 1'b1);
        chk_out("pre_reset", 15, 0, 0, 1, 15, 0, 0, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset.rom_addr", int'(rom_addr), 0);
        chk_out("midreset", 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step(17, 9, 1'b1);
        chk("postreset.rom_addr", int'(rom_addr), 0);
        chk_out("postreset", 1, 2, 3, 0, 1, 2, 3, 0);
        latch(0, 0, 1'b1);
        for (int i = 0; i < 3; i++) step(17, 9, 1'b1);
        chk_out("relatch", 15, 0, 0, 1, 15, 0, 0, 1);

        // Mid-frame position change is held off until the next latch line.
        latch(0, 0, 1'b1);
        pos_x = 10'd200;
        step(17, 100, 1'b1);
        chk("midframe.old_pos", int'(rom_addr), 770);
        step(217, 100, 1'b1);
        chk("midframe.far", int'(rom_addr), 795);
        step(0, 480, 1'b0);
        step(217, 100, 1'b1);
        chk("newframe.new_pos", int'(rom_addr), 770);
        step(17, 100, 1'b1);
        chk("newframe.left", int'(rom_addr), 0);

        // Randomized stream against the screen-space model.
        bg_red = 4'd7; bg_green = 4'd8; bg_blue = 4'd9;
        m_px = 200; m_py = 0; m_en = 1'b1;
        for (int i = 0; i < N_RND; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                pos_x  = 10'($urandom_range(0, 700));
                pos_y  = 10'($urandom_range(0, 500));
                enable = ($urandom_range(0, 3) != 0);
            end
            sel = int'($urandom_range(0, 99));
            if (i == 0 || sel < 3) begin
                x = 0; y = 480; bl = 1'b0;
            end else begin
                if (sel < 55) begin
                    x = (m_px + int'($urandom_range(0, 524)) - 6) % 1024;
                    y = (m_py + int'($urandom_range(0, 396)) - 6) % 1024;
                    if (x < 0) x = 0;
                    if (y < 0) y = 0;
                end else begin
                    x = int'($urandom_range(0, 799));
                    y = int'($urandom_range(0, 524));
                end
                bl = (x < 640) && (y < 480);
                if (sel > 92) bl = ~bl;
            end
            model(x, y, bl, m_px, m_py, m_en, 1'b1, e_addr[i], e_r[i], e_g[i], e_b[i], e_op[i]);
            model(x, y, bl, m_px, m_py, m_en, 1'b0, a2, e_r2[i], e_g2[i], e_b2[i], e_op2[i]);
            if (x == 0 && y == 480) begin
                m_px = int'(pos_x); m_py = int'(pos_y); m_en = enable;
            end
            step(x, y, bl);
            if (i >= 1) chk($sformatf("rnd%0d.rom_addr", i), int'(rom_addr), e_addr[i]);
            if (i >= 2)
                chk_out($sformatf("rnd%0d", i - 2), e_r[i-2], e_g[i-2], e_b[i-2], e_op[i-2],
                        e_r2[i-2], e_g2[i-2], e_b2[i-2], e_op2[i-2]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
